// File: rtl/glitch_pkg.sv
// Shared types and defaults for the glitch pulse generator.
package glitch_pkg;

  localparam int   CNT_W_DEF   = 16;
  localparam int   NUM_W_DEF   = 8;
  localparam logic ACT_LVL_DEF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  function automatic logic inactive_lvl(input logic act);
    return ~act;
  endfunction

endpackage

// File: rtl/glitch_down_cnt.sv
// Loadable down-counter; is_one marks the last cycle of a loaded interval.
module glitch_down_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/glitch_pulse.sv
// Burst glitch generator: once armed, a trigger strobe fires COUNT pulses of WIDTH
// active cycles separated by GAP idle cycles.
//   state | meaning
//   IDLE  | waiting for arm; config inputs are live
//   ARMED | config latched, waiting for trig
//   PULSE | glitch_out active, cycle counter runs the width
//   GAP   | glitch_out inactive between pulses
module glitch_pulse
  import glitch_pkg::*;
#(
  parameter int   CNT_W   = CNT_W_DEF,
  parameter int   NUM_W   = NUM_W_DEF,
  parameter logic ACT_LVL = ACT_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             disarm,
  input  logic             trig,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [NUM_W-1:0] count,
  output logic             glitch_out,
  output logic             busy,
  output logic             done
);

  localparam logic INACT_LVL = inactive_lvl(ACT_LVL);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   width_q, gap_q;
  logic [NUM_W-1:0]   count_q;
  logic               cfg_take;
  logic               cyc_load, cyc_dec, cyc_one;
  logic [CNT_W-1:0]   cyc_val;
  logic               pul_load, pul_dec, pul_one;
  logic               glitch_nx, busy_nx, done_nx;

  glitch_down_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cyc_load),
    .dec      (cyc_dec),
    .load_val (cyc_val),
    .is_one   (cyc_one)
  );

  glitch_down_cnt #(.W(NUM_W)) u_pul_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pul_load),
    .dec      (pul_dec),
    .load_val (count_q),
    .is_one   (pul_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      width_q    <= '0;
      gap_q      <= '0;
      count_q    <= '0;
      glitch_out <= INACT_LVL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      glitch_out <= glitch_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      // zero-valued fields are promoted to 1 so the counters never wrap
      if (cfg_take) begin
        width_q <= (width == '0) ? CNT_W'(1) : width;
        gap_q   <= (gap   == '0) ? CNT_W'(1) : gap;
        count_q <= (count == '0) ? NUM_W'(1) : count;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cfg_take = 1'b0;
    cyc_load = 1'b0;
    cyc_dec  = 1'b0;
    cyc_val  = width_q;
    pul_load = 1'b0;
    pul_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm && !disarm) begin
          cfg_take = 1'b1;
          state_nx = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_nx = ST_IDLE;
        end else if (trig) begin
          cyc_load = 1'b1;
          pul_load = 1'b1;
          state_nx = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (disarm) begin
          state_nx = ST_IDLE;
        end else if (cyc_one) begin
          if (pul_one) begin
            state_nx = ST_IDLE;
          end else begin
            cyc_load = 1'b1;
            cyc_val  = gap_q;
            state_nx = ST_GAP;
          end
        end else begin
          cyc_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (disarm) begin
          state_nx = ST_IDLE;
        end else if (cyc_one) begin
          cyc_load = 1'b1;
          pul_dec  = 1'b1;
          state_nx = ST_PULSE;
        end else begin
          cyc_dec = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    glitch_nx = (state_nx == ST_PULSE) ? ACT_LVL : INACT_LVL;
    busy_nx   = (state_nx != ST_IDLE);
    done_nx   = (state == ST_PULSE) && !disarm && cyc_one && pul_one;
  end

endmodule

// File: tb/tb_glitch_pulse.sv
// Scoreboard bench for glitch_pulse: each queued stimulus cycle carries the expected
// {glitch_out, busy, done} for the cycle that follows its sampling edge.
module tb_glitch_pulse;

  typedef struct {
    logic        a;
    logic        d;
    logic        t;
    logic        r;
    logic [15:0] w;
    logic [15:0] g;
    logic [7:0]  c;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst, arm, disarm, trig;
  logic [15:0] width, gap;
  logic [7:0]  count;
  logic        glitch_out, busy, done;

  logic [15:0] cfg_w, cfg_g;
  logic [7:0]  cfg_c;
  stim_t       stim_q[$];
  logic [2:0]  sb[$];
  int          checks = 0;
  int          errors = 0;

  glitch_pulse dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .disarm     (disarm),
    .trig       (trig),
    .width      (width),
    .gap        (gap),
    .count      (count),
    .glitch_out (glitch_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic a, input logic d, input logic t, input logic r,
                     input logic [2:0] exp);
    stim_t s;
    s.a = a; s.d = d; s.t = t; s.r = r;
    s.w = cfg_w; s.g = cfg_g; s.c = cfg_c;
    stim_q.push_back(s);
    sb.push_back(exp);
  endtask

  // trig cycle plus the full expected burst, done strobe and one trailing idle cycle
  task automatic push_burst(input int w, input int g, input int c);
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < w; i++)
        add(1'b0, 1'b0, (p == 0 && i == 0), 1'b0, 3'b110);
      if (p < c - 1)
        for (int i = 0; i < g; i++)
          add(1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic apply(input stim_t s);
    arm = s.a; disarm = s.d; trig = s.t; rst = s.r;
    width = s.w; gap = s.g; count = s.c;
  endtask

  task automatic test_reset();
    stim_t s;
    logic [2:0] e;
    int n = 0;
    cfg_w = 16'd3; cfg_g = 16'd2; cfg_c = 8'd2;
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    add(1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = sb.pop_front();
      n++;
      checks++;
      if ({glitch_out, busy, done} !== e) begin
        errors++;
        $display("FAIL reset step %0d got %b exp %b", n, {glitch_out, busy, done}, e);
      end
    end
  endtask

  task automatic test_basic();
    stim_t s;
    logic [2:0] e;
    int n = 0;
    cfg_w = 16'd3; cfg_g = 16'd2; cfg_c = 8'd2;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(3, 2, 2);
    cfg_w = 16'd0; cfg_g = 16'd0; cfg_c = 8'd0;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(1, 1, 1);
    cfg_w = 16'd2; cfg_g = 16'd3; cfg_c = 8'd3;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(2, 3, 3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = sb.pop_front();
      n++;
      checks++;
      if ({glitch_out, busy, done} !== e) begin
        errors++;
        $display("FAIL basic step %0d got %b exp %b", n, {glitch_out, busy, done}, e);
      end
    end
  endtask

  task automatic test_disarm();
    stim_t s;
    logic [2:0] e;
    int n = 0;
    cfg_w = 16'd5; cfg_g = 16'd2; cfg_c = 8'd1;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b110);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = sb.pop_front();
      n++;
      checks++;
      if ({glitch_out, busy, done} !== e) begin
        errors++;
        $display("FAIL disarm step %0d got %b exp %b", n, {glitch_out, busy, done}, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    stim_t s;
    logic [2:0] e;
    int n = 0;
    cfg_w = 16'd3; cfg_g = 16'd2; cfg_c = 8'd1;
    add(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    add(1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(3, 2, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = sb.pop_front();
      n++;
      checks++;
      if ({glitch_out, busy, done} !== e) begin
        errors++;
        $display("FAIL simult step %0d got %b exp %b", n, {glitch_out, busy, done}, e);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    stim_t s;
    logic [2:0] e;
    int n = 0;
    cfg_w = 16'd3; cfg_g = 16'd2; cfg_c = 8'd2;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b110);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(3, 2, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = sb.pop_front();
      n++;
      checks++;
      if ({glitch_out, busy, done} !== e) begin
        errors++;
        $display("FAIL rst_gap step %0d got %b exp %b", n, {glitch_out, busy, done}, e);
      end
    end
  endtask

  task automatic test_config_latch();
    stim_t s;
    logic [2:0] e;
    int n = 0;
    cfg_w = 16'd3; cfg_g = 16'd2; cfg_c = 8'd2;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    cfg_w = 16'd9; cfg_g = 16'd7; cfg_c = 8'd5;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(3, 2, 2);
    cfg_w = 16'hFFFF; cfg_g = 16'd0; cfg_c = 8'd1;
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
    push_burst(65535, 1, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = sb.pop_front();
      n++;
      checks++;
      if ({glitch_out, busy, done} !== e) begin
        errors++;
        $display("FAIL cfg_latch step %0d got %b exp %b", n, {glitch_out, busy, done}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; disarm = 1'b0; trig = 1'b0;
    width = '0; gap = '0; count = '0;
    tick();
    test_reset();
    test_basic();
    test_disarm();
    test_simultaneous();
    test_reset_mid_gap();
    test_config_latch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
